// File: rtl/gray_pkg.sv
// Gray-code helpers shared by counters and gray-pointer FIFOs.
// Functions work on 32-bit vectors; callers zero-extend and truncate.
package gray_pkg;

    localparam int MAX_W = 32;

    function automatic logic [MAX_W-1:0] bin2gray(
        input logic [MAX_W-1:0] b
    );
        return b ^ (b >> 1);
    endfunction

    // Zero-extended upper bits stay zero, so this is valid for any width.
    function automatic logic [MAX_W-1:0] gray2bin(
        input logic [MAX_W-1:0] g
    );
        logic [MAX_W-1:0] b;
        b[MAX_W-1] = g[MAX_W-1];
        for (int i = MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/updown_step.sv
// Next binary value for an up/down counter with wrap or saturate limits.
// Ports: bin (current), dir (1=up), ce (enable) -> next, limit (wrap/blocked).
module updown_step #(
    parameter int W        = 4,
    parameter int SATURATE = 0
) (
    input  logic [W-1:0] bin,
    input  logic         dir,
    input  logic         ce,
    output logic [W-1:0] next,
    output logic         limit
);

    localparam logic [W-1:0] ONES = '1;
    localparam logic [W-1:0] ZERO = '0;

    always_comb begin
        next  = bin;
        limit = 1'b0;
        if (ce) begin
            if (dir) begin
                if (bin == ONES) begin
                    limit = 1'b1;
                    next  = (SATURATE != 0) ? bin : ZERO;
                end else begin
                    next = bin + W'(1);
                end
            end else begin
                if (bin == ZERO) begin
                    limit = 1'b1;
                    next  = (SATURATE != 0) ? bin : ONES;
                end else begin
                    next = bin - W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/gray_updown_counter.sv
// Up/down counter with registered Gray output, binary mirror and tc event.
// Ports: clk, rst_n, ce, dir, load, load_val -> cnt (Gray), bin, tc_evt.
module gray_updown_counter
    import gray_pkg::*;
#(
    parameter int           W        = 4,
    parameter int           SATURATE = 0,
    parameter logic [W-1:0] INIT     = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ce,
    input  logic         dir,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] cnt,
    output logic [W-1:0] bin,
    output logic         tc_evt
);

    localparam logic [W-1:0] INIT_G = W'(bin2gray(MAX_W'(INIT)));

    logic [W-1:0] next;
    logic         limit;
    logic [W-1:0] next_g;
    logic [W-1:0] load_g;

    updown_step #(
        .W        (W),
        .SATURATE (SATURATE)
    ) u_step (
        .bin   (bin),
        .dir   (dir),
        .ce    (ce),
        .next  (next),
        .limit (limit)
    );

    assign next_g = W'(bin2gray(MAX_W'(next)));
    assign load_g = W'(bin2gray(MAX_W'(load_val)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin    <= INIT;
            cnt    <= INIT_G;
            tc_evt <= 1'b0;
        end else if (load) begin
            bin    <= load_val;
            cnt    <= load_g;
            tc_evt <= 1'b0;
        end else begin
            // With ce=0 the step module returns bin unchanged, limit=0.
            bin    <= next;
            cnt    <= next_g;
            tc_evt <= limit;
        end
    end

endmodule

// File: doc/gray_updown_counter.md
GRAY_UPDOWN_COUNTER -- requirements
Module: gray_updown_counter

Interface
REQ-001 SHALL have parameter W, default 4: counter width in bits, legal range 2..32.
REQ-002 SHALL have parameter SATURATE, default 0: 0 = wrap at limits, 1 = hold at limits.
REQ-003 SHALL have parameter INIT, default 0: binary reset value, W bits, less than 2^W.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port ce, input, 1 bit: count enable.
REQ-007 SHALL have port dir, input, 1 bit: 1 = count up, 0 = count down.
REQ-008 SHALL have port load, input, 1 bit: synchronous load strobe.
REQ-009 SHALL have port load_val, input, W bits: binary value to load.
REQ-010 SHALL have port cnt, output, W bits: registered Gray-coded count.
REQ-011 SHALL have port bin, output, W bits: registered binary equivalent of cnt.
REQ-012 SHALL have port tc_evt, output, 1 bit: registered terminal-count event.

Function
REQ-013 SHALL give load priority over ce; at an edge with load=1: bin<=load_val, cnt<=bin2gray(load_val), tc_evt<=0, ce and dir ignored.
REQ-014 SHALL, at an edge with load=0, ce=1, dir=1, bin<2^W-1: bin<=bin+1, cnt<=bin2gray(bin+1).
REQ-015 SHALL, at an edge with load=0, ce=1, dir=0, bin>0: bin<=bin-1, cnt<=bin2gray(bin-1).
REQ-016 SHALL, at the upper limit (up, bin=2^W-1) with SATURATE=0, wrap to 0; with SATURATE=1, hold the value.
REQ-017 SHALL, at the lower limit (down, bin=0) with SATURATE=0, wrap to 2^W-1; with SATURATE=1, hold the value.
REQ-018 SHALL set tc_evt=1 for exactly the cycle after an edge at which REQ-016 or REQ-017 applied (wrap or blocked step); otherwise tc_evt=0.
REQ-019 SHALL hold cnt and bin and drive tc_evt=0 at an edge with load=0 and ce=0.
REQ-020 SHALL have latency of one clock: outputs reflect inputs sampled at the preceding rising edge; no combinational input-to-output path.
REQ-021 SHALL change exactly one bit of cnt per counting step, including wrap steps; only load may change several bits.
REQ-022 SHALL keep gray2bin(cnt)==bin in every cycle.
REQ-023 SHALL sample dir freely; a direction change takes effect at the next enabled edge, with no dead cycle.

Reset
REQ-024 SHALL, while rst_n=0, force bin=INIT, cnt=bin2gray(INIT), tc_evt=0 asynchronously, without a clock edge.
REQ-025 SHALL resume counting from INIT at the first rising edge after rst_n deasserts; deassertion synchronisation is the instantiating level's responsibility.

Structure
REQ-026 SHALL take bin2gray and gray2bin as width-generic functions from a shared package, gray_pkg, reused by gray-pointer FIFOs.
REQ-027 SHALL compute the next binary value in one sub-module, updown_step (inputs bin, dir, ce, SATURATE; outputs next value and limit flag); cnt and bin registers live in the top.

Verification
REQ-028 Bench SHALL check: W=4, INIT=0, ce=1, dir=1 for 16 edges -> cnt 0000,0001,0011,0010,0110,...,1000,0000; tc_evt=1 only in the cycle after 1000->0000.
REQ-029 Bench SHALL check: from bin=0, dir=0, ce=1 -> cnt=1000, bin=15, tc_evt=1 for one cycle.
REQ-030 Bench SHALL check: load=1, load_val=9, ce=1 -> cnt=1101, bin=9, tc_evt=0; next edge up -> cnt=1111, bin=10.
REQ-031 Bench SHALL check: SATURATE=1, bin=15, dir=1, ce=1 for 3 edges -> cnt stays 1000, tc_evt=1 each cycle; then dir=0 -> bin=14.
REQ-032 Bench SHALL check: rst_n pulled low mid-cycle at bin=7 with INIT=3 -> bin=3, cnt=0010 before the next edge; ce=0 holds the value.
REQ-033 Bench SHALL check: 1000 cycles of random ce, dir, and load (load 5%) -> every non-load step has Hamming distance 1 and gray2bin(cnt)==bin.
